// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared aluOP, opcode and funct constants plus the issue-entry type
package alu_pkg;

    localparam int ISSUE_XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b1000;
    localparam logic [3:0] ALU_OR    = 4'b1100;
    localparam logic [3:0] ALU_AND   = 4'b1110;
    localparam logic [3:0] ALU_SRL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ISSUE_XLEN-1:0] a;
        logic [ISSUE_XLEN-1:0] b;
        logic [3:0]            aluop;
        logic [4:0]            rd;
        logic                  wen;
        logic                  illegal;
    } issue_entry_t;

    // Operation selected by funct3 when funct7 (or the shift-immediate high bits) is all zero.
    function automatic logic [3:0] base_aluop(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I instruction to ALU issue-entry decoder
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]           inst,
    input  logic [ISSUE_XLEN-1:0] pc,
    input  logic [ISSUE_XLEN-1:0] rs1,
    input  logic [ISSUE_XLEN-1:0] rs2,
    output issue_entry_t          entry
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd;
    logic [ISSUE_XLEN-1:0] imm_i;
    logic [ISSUE_XLEN-1:0] imm_u;
    logic [ISSUE_XLEN-1:0] shamt;
    logic                  legal;
    logic                  unused_reg_fields;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_u  = {inst[31:12], 12'b0};
    assign shamt  = {27'b0, inst[24:20]};

    // Register indices are resolved upstream; only their values reach this stage.
    assign unused_reg_fields = ^inst[19:15];

    always_comb begin
        entry       = '0;
        entry.rd    = rd;
        legal       = 1'b0;

        case (opcode)
            OPC_OP: begin
                entry.a = rs1;
                entry.b = rs2;
                if (funct7 == F7_BASE) begin
                    legal       = 1'b1;
                    entry.aluop = base_aluop(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB) begin
                        legal       = 1'b1;
                        entry.aluop = ALU_SUB;
                    end else if (funct3 == F3_SRL_SRA) begin
                        legal       = 1'b1;
                        entry.aluop = ALU_SRA;
                    end
                end
            end
            OPC_OPIMM: begin
                entry.a = rs1;
                case (funct3)
                    F3_SLL: begin
                        entry.b = shamt;
                        if (funct7 == F7_BASE) begin
                            legal       = 1'b1;
                            entry.aluop = ALU_SLL;
                        end
                    end
                    F3_SRL_SRA: begin
                        entry.b = shamt;
                        if (funct7 == F7_BASE) begin
                            legal       = 1'b1;
                            entry.aluop = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            legal       = 1'b1;
                            entry.aluop = ALU_SRA;
                        end
                    end
                    default: begin
                        entry.b     = imm_i;
                        legal       = 1'b1;
                        entry.aluop = base_aluop(funct3);
                    end
                endcase
            end
            OPC_LUI: begin
                entry.a     = '0;
                entry.b     = imm_u;
                entry.aluop = ALU_PASSB;
                legal       = 1'b1;
            end
            OPC_AUIPC: begin
                entry.a     = pc;
                entry.b     = imm_u;
                entry.aluop = ALU_ADD;
                legal       = 1'b1;
            end
            default: ;
        endcase

        // Illegal encodings issue as a harmless ADD 0+0 with no writeback.
        if (legal) begin
            entry.wen     = (rd != 5'd0);
            entry.illegal = 1'b0;
        end else begin
            entry.a       = '0;
            entry.b       = '0;
            entry.aluop   = ALU_ADD;
            entry.wen     = 1'b0;
            entry.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: decode plus two-entry skid buffer toward the EXU
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = ISSUE_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_aluop,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    issue_entry_t dec_entry;
    issue_entry_t main_q;
    issue_entry_t skid_q;
    logic         main_valid;
    logic         skid_valid;
    logic         accept;
    logic         drain;

    alu_op_decode u_decode (
        .inst  (in_inst),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .entry (dec_entry)
    );

    // in_ready comes straight from the skid flop, so there is no path from out_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            // Skid is never full while main is empty, and accept is blocked while skid is full,
            // so the skid entry always has priority and cannot collide with a new entry.
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec_entry;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_aluop   = main_q.aluop;
    assign out_rd      = main_q.rd;
    assign out_wen     = main_q.wen;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_wen, out_illegal;
    logic [31:0] in_inst, in_pc, in_rs1, in_rs2, out_a, out_b;
    logic [3:0]  out_aluop;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_aluop   (out_aluop),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    int   out_count = 0;
    bit   model_on = 1'b0;
    ent_t model_q[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0010;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b1000;
            3'd5:    return 4'b1010;
            3'd6:    return 4'b1100;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic ent_t ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        ent_t        e;
        bit          ok = 1'b0;
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        logic [3:0]  op = 4'd0;
        logic [6:0]  opc = inst[6:0];
        logic [2:0]  f3 = inst[14:12];
        logic [6:0]  f7 = inst[31:25];
        if (opc == 7'h33) begin
            a = rs1;
            b = rs2;
            if (f7 == 7'h00) begin ok = 1'b1; op = base_op(f3); end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; op = 4'b0001; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 4'b1011; end
        end else if (opc == 7'h13) begin
            a = rs1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = {27'd0, inst[24:20]};
                if (f7 == 7'h00) begin ok = 1'b1; op = base_op(f3); end
                else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; op = 4'b1011; end
            end else begin
                b  = {{20{inst[31]}}, inst[31:20]};
                ok = 1'b1;
                op = base_op(f3);
            end
        end else if (opc == 7'h37) begin
            ok = 1'b1; a = 32'd0; b = {inst[31:12], 12'h000}; op = 4'b1001;
        end else if (opc == 7'h17) begin
            ok = 1'b1; a = pc; b = {inst[31:12], 12'h000}; op = 4'b0000;
        end
        e.rd = inst[11:7];
        if (ok) begin
            e.a = a; e.b = b; e.op = op; e.wen = (inst[11:7] != 5'd0); e.ill = 1'b0;
        end else begin
            e.a = 32'd0; e.b = 32'd0; e.op = 4'd0; e.wen = 1'b0; e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] r  = $urandom;
        logic [31:0] r2 = $urandom;
        logic [2:0]  f3 = r[14:12];
        logic [6:0]  f7;
        int          k  = int'($urandom_range(0, 3));
        case (k)
            0: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r2[0]) ? 7'h20 : 7'h00;
                return {f7, r[24:15], f3, r[11:7], 7'h33};
            end
            1: begin
                if (f3 == 3'd1)      f7 = 7'h00;
                else if (f3 == 3'd5) f7 = r2[0] ? 7'h20 : 7'h00;
                else                 f7 = r[31:25];
                return {f7, r[24:15], f3, r[11:7], 7'h13};
            end
            2:       return {r[31:12], r[11:7], 7'h37};
            default: return {r[31:12], r[11:7], 7'h17};
        endcase
    endfunction

    // Model: an in-order queue of at most two decoded entries; ready means the queue is not full.
    always @(negedge clk) begin : compare
        ent_t got;
        bit   acc;
        if (model_on) begin
            chk("in_ready", in_ready, model_q.size() < 2);
            if (model_q.size() == 0) begin
                chk("out_valid_idle", out_valid, 1'b0);
            end else begin
                chk("out_valid_busy", out_valid, 1'b1);
                got.a = out_a; got.b = out_b; got.op = out_aluop;
                got.rd = out_rd; got.wen = out_wen; got.ill = out_illegal;
                chk("out_entry", got, model_q[0]);
            end
            if (out_valid === 1'b1 && out_ready) out_count++;
            if (rst || flush) begin
                model_q.delete();
            end else begin
                acc = in_valid && (model_q.size() < 2);
                if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
                if (acc) model_q.push_back(ref_decode(in_inst, in_pc, in_rs1, in_rs2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1; in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_a"}, out_a, 32'd0);
        chk({tag, "_out_b"}, out_b, 32'd0);
        chk({tag, "_out_aluop"}, out_aluop, 4'd0);
        chk({tag, "_out_rd"}, out_rd, 5'd0);
        chk({tag, "_out_wen"}, out_wen, 1'b0);
        chk({tag, "_out_illegal"}, out_illegal, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0;
        step();
        step();
        chk_reset_values("reset");
        rst = 1'b0;
        model_on = 1'b1;
        step();

        // Directed decode vectors, one instruction at a time with the EXU always ready.
        out_ready = 1'b1;
        send(32'h002081B3, 32'd0, 32'd5, 32'd7);
        chk("add_valid", out_valid, 1'b1);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_op", out_aluop, 4'b0000);
        chk("add_rd", out_rd, 5'd3);
        chk("add_wen", out_wen, 1'b1);
        send(32'h402083B3, 32'd0, 32'd10, 32'd3);
        chk("sub_op", out_aluop, 4'b0001);
        send(32'h4030D213, 32'd0, 32'h80000000, 32'd0);
        chk("srai_op", out_aluop, 4'b1011);
        chk("srai_b", out_b, 32'd3);
        chk("srai_a", out_a, 32'h80000000);
        send(32'h02309213, 32'd0, 32'd9, 32'd0);
        chk("slli_bad_ill", out_illegal, 1'b1);
        chk("slli_bad_wen", out_wen, 1'b0);
        chk("slli_bad_a", out_a, 32'd0);
        send(32'h123452B7, 32'd0, 32'hDEAD, 32'd0);
        chk("lui_a", out_a, 32'd0);
        chk("lui_b", out_b, 32'h12345000);
        chk("lui_op", out_aluop, 4'b1001);
        chk("lui_rd", out_rd, 5'd5);
        send(32'h00001317, 32'h80000000, 32'd0, 32'd0);
        chk("auipc_a", out_a, 32'h80000000);
        chk("auipc_b", out_b, 32'h00001000);
        chk("auipc_op", out_aluop, 4'b0000);
        send(32'h00000073, 32'd0, 32'd1, 32'd2);
        chk("sys_ill", out_illegal, 1'b1);
        chk("sys_wen", out_wen, 1'b0);
        step();
        chk("idle_valid", out_valid, 1'b0);

        // Backpressure: three back-to-back offers with the EXU stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'd0; in_rs2 = 32'd0;
        in_inst = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33); in_rs1 = 32'd1;
        step();
        in_inst = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd11, 7'h33); in_rs1 = 32'd2;
        step();
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_hold_rd", out_rd, 5'd10);
        in_inst = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd12, 7'h33); in_rs1 = 32'd3;
        step();
        chk("bp_still_low", in_ready, 1'b0);
        chk("bp_stable_a", out_a, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_second_rd", out_rd, 5'd11);
        chk("bp_ready_back", in_ready, 1'b1);
        step();
        chk("bp_third_rd", out_rd, 5'd12);
        in_valid = 1'b0;
        step();
        chk("bp_empty", out_valid, 1'b0);

        // Full-rate stream of random legal instructions.
        out_count = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_inst = gen_legal();
            in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom;
            step();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_ill", out_illegal, 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk("stream_count", out_count, 100);

        // Flush with both entries occupied and a new offer in the same cycle.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h123452B7;
        step();
        in_inst = 32'h00001317;
        step();
        flush = 1'b1; in_inst = 32'h002081B3;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        step();
        chk("flush_dropped", out_valid, 1'b0);

        // Reset in the middle of traffic with both entries occupied.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = gen_legal(); in_rs1 = $urandom; in_rs2 = $urandom;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_inst = gen_legal(); in_rs1 = $urandom;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk_reset_values("midreset");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
